// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft
// Read-side output stage of the asynchronous FIFO. It turns the FIFO pop
// interface (r_en/empty, data returned one cycle after the pop) into a
// first-word-fall-through valid/ready stream through a 2-entry buffer.
// Words are delivered in pop order at up to one word per cycle.
//
// Ports:
//   r_clk      read-domain clock
//   r_rst      synchronous active-high reset
//   empty      FIFO empty flag (registered in r_clk domain)
//   r_data     memory read data, valid the cycle after an accepted pop
//   r_en       pop request to read pointer logic and memory
//   out_valid  head word available
//   out_data   head word, held while out_valid=1 and out_ready=0
//   out_ready  consumer accepts the head word
//   buf_level  buffer occupancy 0..2 (only when FWFT_LEVEL_EN is defined)
//
// Build option: define FWFT_LEVEL_EN to expose the buf_level port.

module fifo_rd_fwft #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef FWFT_LEVEL_EN
  ,
  output logic [1:0]            buf_level
`endif
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  logic                  pop_out;
  logic [2:0]            pending;
  logic [1:0]            occ_a;
  logic [1:0]            occ_n;
  logic [DATA_WIDTH-1:0] entry0_n;
  logic [DATA_WIDTH-1:0] entry1_n;

  assign out_valid = (occ != 2'd0);
  assign out_data  = entry0;
  assign pop_out   = out_valid & out_ready;

  // Words already buffered plus the one on its way back from memory. A new
  // pop is allowed only if a slot is guaranteed when its data returns; a
  // consumer pop this cycle frees one, which keeps streaming gap-free.
  always_comb begin
    pending = {1'b0, occ} + {2'b00, inflight};
    r_en    = !r_rst && !empty &&
              ((pending < 3'd2) || ((pending == 3'd2) && pop_out));
  end

  // Consumer pop shifts the tail forward first; the returning word then
  // fills the first free slot of the post-shift buffer.
  always_comb begin
    occ_a    = occ;
    entry0_n = entry0;
    entry1_n = entry1;
    if (pop_out) begin
      occ_a    = occ - 2'd1;
      entry0_n = entry1;
    end
    occ_n = occ_a;
    if (inflight) begin
      if (occ_a == 2'd0) begin
        entry0_n = r_data;
      end else begin
        entry1_n = r_data;
      end
      occ_n = occ_a + 2'd1;
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      entry0   <= '0;
      entry1   <= '0;
    end else begin
      occ      <= occ_n;
      inflight <= r_en;
      entry0   <= entry0_n;
      entry1   <= entry1_n;
    end
  end

`ifdef FWFT_LEVEL_EN
  assign buf_level = occ;
`endif

  // A return into a full buffer would drop a word; the r_en gating above
  // is meant to make this impossible.
  a_no_overflow: assert property (@(posedge r_clk) disable iff (r_rst)
    !(inflight && (occ_a == 2'd2)));

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft
// Self-checking bench for fifo_rd_fwft: a cycle vector table for reset and a
// single-word transfer, then scoreboard-driven sequences for streaming,
// back-pressure, simultaneous shift/return and mid-operation reset.

module tb_fifo_rd_fwft;

  logic       r_clk;
  logic       r_rst;
  logic       empty;
  logic [7:0] r_data;
  logic       r_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef FWFT_LEVEL_EN
  logic [1:0] buf_level;
`endif

  fifo_rd_fwft #(.DATA_WIDTH(8)) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .empty     (empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef FWFT_LEVEL_EN
    ,
    .buf_level (buf_level)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  typedef struct packed {
    logic       rst;
    logic       emp;
    logic [7:0] rd;
    logic       rdy;
    logic       exp_ren;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl [8];
  int         n_chk  = 0;
  int         n_pass = 0;

  logic [7:0] src_q [$];
  logic [7:0] exp_q [$];
  int         cyc      = 0;
  int         pop_cnt  = 0;
  int         acc_cnt  = 0;
  int         acc_first = -1;
  int         acc_last  = -1;
  logic       last_ren  = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  function automatic vec_t mk(logic rst, logic emp, logic [7:0] rd, logic rdy,
                              logic er, logic ev, logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.emp = emp; v.rd = rd; v.rdy = rdy;
    v.exp_ren = er; v.exp_vld = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle driven by the source model: outputs are sampled on the
  // falling edge, memory data for an accepted pop is presented after the
  // rising edge and the word is queued as an expected output.
  task automatic cycle();
    logic       pop;
    logic [7:0] w;
    empty = (src_q.size() == 0);
    @(negedge r_clk);
    cyc++;
    last_ren = r_en;
    if (r_en) chk("ren_while_empty", {31'd0, empty}, 32'd0);
    pop = r_en && !empty;
    if (pop) pop_cnt++;
    if (out_valid && out_ready && !r_rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious", {31'd0, out_valid}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", {24'd0, out_data}, {24'd0, w});
      end
      acc_cnt++;
      if (acc_first < 0) acc_first = cyc;
      acc_last = cyc;
    end
    if (out_valid && !out_ready && hold_prev)
      chk("hold_stable", {24'd0, out_data}, {24'd0, hold_data});
    hold_prev = out_valid && !out_ready && !r_rst;
    hold_data = out_data;
    @(posedge r_clk);
    #1;
    if (pop) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
      r_data = w;
    end else begin
      r_data = 8'($urandom_range(0, 255));
    end
    empty = (src_q.size() == 0);
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    out_ready = 1'b0;
    src_q.delete();
    exp_q.delete();
    cycle();
    cycle();
    r_rst = 1'b0;
    hold_prev = 1'b0;
    pop_cnt = 0;
    acc_cnt = 0;
    acc_first = -1;
    acc_last = -1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    chk({name, "_drain_left"}, exp_q.size() + src_q.size(), 32'd0);
  endtask

  initial begin
    r_rst = 1'b1;
    empty = 1'b0;
    r_data = 8'h00;
    out_ready = 1'b1;

    tbl[0] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00);
    tbl[1] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00);
    tbl[2] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00);
    tbl[3] = mk(0, 0, 8'h00, 1, 1, 0, 8'h00);
    tbl[4] = mk(0, 1, 8'hA5, 1, 0, 0, 8'h00);
    tbl[5] = mk(0, 1, 8'h3C, 1, 0, 1, 8'hA5);
    tbl[6] = mk(0, 1, 8'h5A, 1, 0, 0, 8'h00);
    tbl[7] = mk(1, 0, 8'h00, 1, 0, 0, 8'h00);

    @(posedge r_clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge r_clk);
      #1;
      r_rst = tbl[i].rst;
      empty = tbl[i].emp;
      r_data = tbl[i].rd;
      out_ready = tbl[i].rdy;
      @(negedge r_clk);
      chk($sformatf("vec%0d_r_en", i), {31'd0, r_en}, {31'd0, tbl[i].exp_ren});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_vld});
      chk($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].exp_data});
`ifdef FWFT_LEVEL_EN
      if (tbl[i].rst) chk($sformatf("vec%0d_level", i), {30'd0, buf_level}, 32'd0);
`endif
    end
    @(posedge r_clk);
    #1;

    // Streaming: 16 words with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    drain("stream");
    repeat (3) cycle();
    chk("stream_count", acc_cnt, 32'd16);
    chk("stream_gapless", acc_last - acc_first, 32'd15);

    // Back-pressure: only two pops may be issued while the consumer stalls.
    do_reset();
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    repeat (8) cycle();
    chk("bp_pops", pop_cnt, 32'd2);
    chk("bp_r_en_low", {31'd0, last_ren}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_data", {24'd0, out_data}, 32'h11);
`ifdef FWFT_LEVEL_EN
    chk("bp_level", {30'd0, buf_level}, 32'd2);
`endif
    out_ready = 1'b1;
    cycle();
    chk("bp_r_en_resume", {31'd0, last_ren}, 32'd1);
    drain("bp");
    repeat (3) cycle();
    chk("bp_delivered", acc_cnt, 32'd3);

    // Consumer pop and memory return in the same cycle with one word held.
    do_reset();
    src_q.push_back(8'h44);
    repeat (4) cycle();
    chk("sim_head", {24'd0, out_data}, 32'h44);
    src_q.push_back(8'h55);
    cycle();
    out_ready = 1'b1;
    cycle();
    chk("sim_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sim_out_data", {24'd0, out_data}, 32'h55);
`ifdef FWFT_LEVEL_EN
    chk("sim_level", {30'd0, buf_level}, 32'd1);
`endif
    drain("sim");
    repeat (2) cycle();
    chk("sim_delivered", acc_cnt, 32'd2);

    // Reset while the buffer holds a word and another is returning.
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(8'h66 + 8'(i * 17));
    repeat (4) cycle();
    out_ready = 1'b1;
    cycle();
    r_rst = 1'b1;
    out_ready = 1'b0;
    cycle();
    exp_q.delete();
    src_q.delete();
    r_rst = 1'b0;
    hold_prev = 1'b0;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef FWFT_LEVEL_EN
    chk("mr_level", {30'd0, buf_level}, 32'd0);
`endif
    cycle();
    chk("mr_r_en_idle", {31'd0, last_ren}, 32'd0);
    chk("mr_no_stale", {31'd0, out_valid}, 32'd0);
    acc_cnt = 0;
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    out_ready = 1'b1;
    drain("mr");
    repeat (3) cycle();
    chk("mr_delivered", acc_cnt, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
